// File: rtl/trdb_resync_timer.sv
`default_nettype none
// ============================================================================
// Module   : trdb_resync_timer
// Brief    : Resync timer that counts cycles or emitted non-sync packets and
//            requests a forced F_SYNC packet once a runtime threshold is hit.
// Revision : 1.0 - initial release
// ============================================================================
module trdb_resync_timer #(
    parameter int unsigned CNT_W       = 16,
    parameter logic [1:0]  MODE_CYCLE  = 2'd0,
    parameter logic [1:0]  MODE_PACKET = 2'd1,
    parameter logic [1:0]  MODE_OFF    = 2'd2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] max_i,
    input  logic             pkt_valid_i,
    input  logic             pkt_is_sync_i,
    output logic             resync_req_o,
    input  logic             resync_ack_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COUNT   = 2'd1;
    localparam logic [1:0] c_ST_PENDING = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [1:0]       r_mode;

    logic             w_active;
    logic             w_mode_chg;
    logic             w_sync;
    logic             w_inc;
    logic [CNT_W:0]   w_count_inc;
    logic             w_reached;
    logic             w_over;

    assign w_active    = enable_i
                       && ((mode_i == MODE_CYCLE) || (mode_i == MODE_PACKET))
                       && (max_i != '0);
    assign w_mode_chg  = (mode_i != r_mode);
    assign w_sync      = pkt_valid_i && pkt_is_sync_i;
    assign w_inc       = (mode_i == MODE_CYCLE) || (pkt_valid_i && !pkt_is_sync_i);
    // One extra bit so the increment can never wrap even at the all-ones threshold.
    assign w_count_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
    assign w_reached   = (w_count_inc >= {1'b0, max_i});
    assign w_over      = (r_count >= max_i);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
            r_mode  <= MODE_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_mode  <= mode_i;
        end
    end

    // Next-state and counter update
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            c_ST_IDLE: begin
                w_count_nxt = '0;
                if (w_active) begin
                    w_state_nxt = c_ST_COUNT;
                end
            end
            c_ST_COUNT: begin
                if (!w_active) begin
                    w_state_nxt = c_ST_IDLE;
                    w_count_nxt = '0;
                end else if (w_mode_chg || w_sync) begin
                    w_count_nxt = '0;
                end else if (w_over) begin
                    // Threshold lowered below the running count: request without counting on.
                    w_state_nxt = c_ST_PENDING;
                end else if (w_inc) begin
                    w_count_nxt = w_count_inc[CNT_W-1:0];
                    if (w_reached) begin
                        w_state_nxt = c_ST_PENDING;
                    end
                end
            end
            c_ST_PENDING: begin
                if (!w_active) begin
                    w_state_nxt = c_ST_IDLE;
                    w_count_nxt = '0;
                end else if (w_mode_chg || resync_ack_i || w_sync) begin
                    w_state_nxt = c_ST_COUNT;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // Outputs decode registers only
    always_comb begin
        resync_req_o = (r_state == c_ST_PENDING);
        count_o      = r_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_trdb_resync_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_trdb_resync_timer
// Brief    : Self-checking bench for trdb_resync_timer (CNT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_trdb_resync_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] mx;
    logic       pv;
    logic       ps;
    logic       ack;
    logic       req;
    logic [3:0] count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference: a running flag, a pending flag and an integer count
    bit m_run;
    bit m_req;
    int m_cnt;
    int m_prev;

    trdb_resync_timer #(.CNT_W(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .enable_i      (en),
        .mode_i        (mode),
        .max_i         (mx),
        .pkt_valid_i   (pv),
        .pkt_is_sync_i (ps),
        .resync_req_o  (req),
        .resync_ack_i  (ack),
        .count_o       (count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        bit act;
        bit chg;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            act = en && (mode == 2'd0 || mode == 2'd1) && (mx != 0);
            chg = (int'(mode) != m_prev);
            m_prev = int'(mode);
            if (!rst_n) begin
                m_run = 0; m_req = 0; m_cnt = 0; m_prev = 2;
            end else if (!m_run) begin
                m_cnt = 0; m_req = 0; m_run = act;
            end else if (!act) begin
                m_run = 0; m_req = 0; m_cnt = 0;
            end else if (chg) begin
                m_req = 0; m_cnt = 0;
            end else if (m_req) begin
                if (ack || (pv && ps)) begin m_req = 0; m_cnt = 0; end
            end else if (pv && ps) begin
                m_cnt = 0;
            end else if (m_cnt >= int'(mx)) begin
                m_req = 1;
            end else if (mode == 2'd0 || pv) begin
                m_cnt = m_cnt + 1;
                if (m_cnt >= int'(mx)) m_req = 1;
            end
        end
    endtask

    task automatic start(input logic [1:0] md, input logic [3:0] mxv);
        rst_n = 0; en = 0; mode = md; mx = mxv; pv = 0; ps = 0; ack = 0;
        tick(1);
        rst_n = 1; en = 1;
        tick(1);
    endtask

    task automatic pulse(input logic sync);
        pv = 1; ps = sync;
        tick(1);
        pv = 0; ps = 0;
        tick(2);
    endtask

    task automatic test_reset();
        rst_n = 0; en = 1; mode = 2'd0; mx = 4'd4; pv = 1; ps = 0; ack = 1;
        tick(2);
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d exp 0", count); end
        n_checks++; if (req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %0b exp 0", req); end
    endtask

    task automatic test_cycle_basic();
        start(2'd0, 4'd4);
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL t1_start: got %0d exp 0", count); end
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            n_checks++; if (count !== 4'(i)) begin n_errors++; $display("FAIL t1_count: got %0d exp %0d", count, i); end
            n_checks++; if (req !== (i == 4)) begin n_errors++; $display("FAIL t1_req: got %0b exp %0b", req, i == 4); end
        end
        tick(2);
        n_checks++; if (count !== 4'd4 || req !== 1'b1) begin n_errors++; $display("FAIL t1_hold: got %0d/%0b exp 4/1", count, req); end
        ack = 1;
        tick(1);
        ack = 0;
        n_checks++; if (count !== 4'd0 || req !== 1'b0) begin n_errors++; $display("FAIL t1_ack: got %0d/%0b exp 0/0", count, req); end
        tick(1);
        n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL t1_restart: got %0d exp 1", count); end
    endtask

    task automatic test_packet();
        start(2'd1, 4'd3);
        pulse(0);
        n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL t2_p1: got %0d exp 1", count); end
        pulse(0);
        n_checks++; if (count !== 4'd2 || req !== 1'b0) begin n_errors++; $display("FAIL t2_p2: got %0d/%0b exp 2/0", count, req); end
        pulse(1);
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL t2_sync: got %0d exp 0", count); end
        pulse(0);
        pulse(0);
        n_checks++; if (count !== 4'd2 || req !== 1'b0) begin n_errors++; $display("FAIL t2_p5: got %0d/%0b exp 2/0", count, req); end
        pulse(0);
        n_checks++; if (count !== 4'd3 || req !== 1'b1) begin n_errors++; $display("FAIL t2_p6: got %0d/%0b exp 3/1", count, req); end
    endtask

    task automatic test_simultaneous();
        start(2'd0, 4'd5);
        ack = 1;
        tick(4);
        ack = 0;
        n_checks++; if (count !== 4'd4 || req !== 1'b0) begin n_errors++; $display("FAIL t3_ack_ignored: got %0d/%0b exp 4/0", count, req); end
        pv = 1; ps = 1;
        tick(1);
        pv = 0; ps = 0;
        n_checks++; if (count !== 4'd0 || req !== 1'b0) begin n_errors++; $display("FAIL t3_sync_wins: got %0d/%0b exp 0/0", count, req); end
        tick(5);
        n_checks++; if (count !== 4'd5 || req !== 1'b1) begin n_errors++; $display("FAIL t3_pending: got %0d/%0b exp 5/1", count, req); end
        ack = 1; pv = 1; ps = 1;
        tick(1);
        ack = 0; pv = 0; ps = 0;
        n_checks++; if (count !== 4'd0 || req !== 1'b0) begin n_errors++; $display("FAIL t3_dual: got %0d/%0b exp 0/0", count, req); end
        tick(1);
        n_checks++; if (count !== 4'd1 || req !== 1'b0) begin n_errors++; $display("FAIL t3_after: got %0d/%0b exp 1/0", count, req); end
    endtask

    task automatic test_saturate();
        start(2'd0, 4'd15);
        tick(15);
        n_checks++; if (count !== 4'd15 || req !== 1'b1) begin n_errors++; $display("FAIL t4_top: got %0d/%0b exp 15/1", count, req); end
        for (int i = 0; i < 10; i++) begin
            tick(1);
            n_checks++; if (count !== 4'd15 || req !== 1'b1) begin n_errors++; $display("FAIL t4_hold: got %0d/%0b exp 15/1", count, req); end
        end
        mx = 4'd10; ack = 1;
        tick(1);
        ack = 0;
        tick(7);
        n_checks++; if (count !== 4'd7 || req !== 1'b0) begin n_errors++; $display("FAIL t4_seven: got %0d/%0b exp 7/0", count, req); end
        mx = 4'd5;
        tick(1);
        n_checks++; if (req !== 1'b1) begin n_errors++; $display("FAIL t4_lowered: got %0b exp 1", req); end
    endtask

    task automatic test_off();
        start(2'd0, 4'd0);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) mode = 2'd1;
            tick(1);
            n_checks++; if (count !== 4'd0 || req !== 1'b0) begin n_errors++; $display("FAIL t5_max0: got %0d/%0b exp 0/0", count, req); end
        end
        mx = 4'd2; mode = 2'd2; pv = 1;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) mode = 2'd3;
            tick(1);
            n_checks++; if (count !== 4'd0 || req !== 1'b0) begin n_errors++; $display("FAIL t5_off: got %0d/%0b exp 0/0", count, req); end
        end
        pv = 0;
    endtask

    task automatic test_deactivate();
        start(2'd0, 4'd3);
        tick(3);
        n_checks++; if (req !== 1'b1) begin n_errors++; $display("FAIL t6_pend: got %0b exp 1", req); end
        en = 0;
        tick(1);
        n_checks++; if (count !== 4'd0 || req !== 1'b0) begin n_errors++; $display("FAIL t6_disable: got %0d/%0b exp 0/0", count, req); end
        en = 1;
        tick(3);
        n_checks++; if (count !== 4'd2) begin n_errors++; $display("FAIL t6_reenable: got %0d exp 2", count); end
        rst_n = 0;
        tick(1);
        rst_n = 1;
        n_checks++; if (count !== 4'd0 || req !== 1'b0) begin n_errors++; $display("FAIL t6_reset: got %0d/%0b exp 0/0", count, req); end
        tick(3);
        n_checks++; if (count !== 4'd2) begin n_errors++; $display("FAIL t6_recount: got %0d exp 2", count); end
        mode = 2'd1;
        tick(1);
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL t6_modechg: got %0d exp 0", count); end
        tick(2);
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL t6_pktidle: got %0d exp 0", count); end
        pulse(0);
        n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL t6_pkt: got %0d exp 1", count); end
    endtask

    task automatic test_random();
        start(2'd0, 4'd3);
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0)
                mx = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
            pv  = ($urandom_range(0, 9) < 4);
            ps  = ($urandom_range(0, 4) == 0);
            ack = ($urandom_range(0, 9) == 0);
            tick(1);
            n_checks++; if (count !== 4'(m_cnt)) begin n_errors++; $display("FAIL rand_count: cycle %0d got %0d exp %0d", i, count, m_cnt); end
            n_checks++; if (req !== m_req) begin n_errors++; $display("FAIL rand_req: cycle %0d got %0b exp %0b", i, req, m_req); end
        end
    endtask

    initial begin
        m_run = 0; m_req = 0; m_cnt = 0; m_prev = 2;
        rst_n = 0; en = 0; mode = 2'd2; mx = 4'd0; pv = 0; ps = 0; ack = 0;
        test_reset();
        test_cycle_basic();
        test_packet();
        test_simultaneous();
        test_saturate();
        test_off();
        test_deactivate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
